// File: rtl/ctrl_packet_scheduler.sv
// ctrl_packet_scheduler
//
// Builds 4-byte control packets (SYNC_BYTE, steering, button, checksum) and
// streams them to a UART transmit path with a valid/ready handshake.
// A packet is requested by the periodic tick or by a change of the button
// vector. Requests arriving while a packet is in flight merge into one
// follow-up packet.
//
// Optional build macro: DEBOUNCE_EN
//   defined   -> each button bit passes through a DEB_CYCLES stability filter
//                before change detection and snapshotting
//   undefined -> raw btn_in_i is used and DEB_CYCLES has no effect
//
// Ports
//   fab_clk_i      fabric clock, all logic on its rising edge
//   fab_rst_i      synchronous active-high reset
//   steer_in_i     ADC steering sample
//   steer_valid_i  loads steer_in_i into the steering register
//   btn_in_i       button levels, already synchronised to fab_clk_i
//   tx_data_o      byte to UART, 8'h00 while tx_valid_o is low
//   tx_valid_o     tx_data_o valid
//   tx_ready_i     UART accepts the byte when tx_valid_o is also high
//   busy_o         high whenever the scheduler is not idle
//   pkt_count_o    completed packet count, wraps 255 -> 0
//
// state   | meaning
// --------+-----------------------------------------------------
// S_IDLE  | waiting for a pending request
// S_LATCH | snapshot steering register and button vector
// S_SYNC  | presenting SYNC_BYTE
// S_STEER | presenting steering snapshot
// S_BTN   | presenting {6'b0, button snapshot}
// S_CSUM  | presenting checksum; handshake completes the packet

module ctrl_packet_scheduler #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned DEB_CYCLES = 1000
) (
    input  logic       fab_clk_i,
    input  logic       fab_rst_i,
    input  logic [7:0] steer_in_i,
    input  logic       steer_valid_i,
    input  logic [1:0] btn_in_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic [7:0] pkt_count_o
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SYNC,
        S_STEER,
        S_BTN,
        S_CSUM
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic             pending_q, pending_d;
    logic [7:0]       steer_q, steer_d;
    logic [7:0]       snap_steer_q, snap_steer_d;
    logic [1:0]       snap_btn_q, snap_btn_d;
    logic [1:0]       btn_prev_q;
    logic [1:0]       btn_cur;
    logic             btn_change;
    logic [7:0]       pkt_count_q, pkt_count_d;
    logic [7:0]       csum;
    logic             leave_idle;
    logic             pkt_done;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
`ifdef DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]            deb_q, deb_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // The counter tracks how many consecutive samples have disagreed with the
    // filtered value; any agreeing sample restarts the window.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (btn_in_i[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_d[b]     = btn_in_i[b];
                    deb_cnt_d[b] = '0;
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end
            end else begin
                deb_cnt_d[b] = '0;
            end
        end
    end

    always_ff @(posedge fab_clk_i) begin
        if (fab_rst_i) begin
            deb_q     <= 2'b00;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_cur = deb_q;
`else
    assign btn_cur = btn_in_i;
`endif

    assign btn_change = (btn_cur != btn_prev_q);

    // ------------------------------------------------------------------
    // Tick counter and request tracking
    // ------------------------------------------------------------------
    assign tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // A new event in the same cycle as the IDLE->LATCH clear must survive,
    // so the set terms are applied after the clear.
    assign pending_d = (pending_q & ~leave_idle) | tick | btn_change;

    assign steer_d      = steer_valid_i ? steer_in_i : steer_q;
    assign snap_steer_d = (state_q == S_LATCH) ? steer_q : snap_steer_q;
    assign snap_btn_d   = (state_q == S_LATCH) ? btn_cur : snap_btn_q;
    assign pkt_count_d  = pkt_done ? pkt_count_q + 8'd1 : pkt_count_q;

    assign csum = SYNC_BYTE + snap_steer_q + {6'b000000, snap_btn_q};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge fab_clk_i) begin
        if (fab_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        leave_idle = 1'b0;
        pkt_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d    = S_LATCH;
                    leave_idle = 1'b1;
                end
            end
            S_LATCH: begin
                state_d = S_SYNC;
            end
            S_SYNC: begin
                tx_valid_o = 1'b1;
                tx_data_o  = SYNC_BYTE;
                if (tx_ready_i) state_d = S_STEER;
            end
            S_STEER: begin
                tx_valid_o = 1'b1;
                tx_data_o  = snap_steer_q;
                if (tx_ready_i) state_d = S_BTN;
            end
            S_BTN: begin
                tx_valid_o = 1'b1;
                tx_data_o  = {6'b000000, snap_btn_q};
                if (tx_ready_i) state_d = S_CSUM;
            end
            S_CSUM: begin
                tx_valid_o = 1'b1;
                tx_data_o  = csum;
                if (tx_ready_i) begin
                    state_d  = S_IDLE;
                    pkt_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge fab_clk_i) begin
        if (fab_rst_i) begin
            tick_cnt_q   <= '0;
            pending_q    <= 1'b0;
            steer_q      <= 8'h80;
            snap_steer_q <= 8'h00;
            snap_btn_q   <= 2'b00;
            btn_prev_q   <= 2'b00;
            pkt_count_q  <= 8'h00;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            pending_q    <= pending_d;
            steer_q      <= steer_d;
            snap_steer_q <= snap_steer_d;
            snap_btn_q   <= snap_btn_d;
            btn_prev_q   <= btn_cur;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign pkt_count_o = pkt_count_q;

endmodule

// File: doc/ctrl_packet_scheduler.md
CTRL_PACKET_SCHEDULER -- requirements
Module: ctrl_packet_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000: FAB_CLK cycles between periodic packets; legal range 2..2^20.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: first byte of every packet.
REQ-003 Parameter DEB_CYCLES, default 1000: debounce stability window in cycles; used only when DEBOUNCE_EN is defined.
REQ-004 FAB_CLK  in  1  single fabric clock; all logic on its rising edge.
REQ-005 FAB_RST  in  1  reset, synchronous, active-high.
REQ-006 STEER_IN  in  8  ADC steering sample.
REQ-007 STEER_VALID  in  1  STEER_IN qualifier; steering register loads when high.
REQ-008 BTN_IN  in  2  button levels from GPIO_0_IN/GPIO_1_IN, already synchronised to FAB_CLK.
REQ-009 TX_DATA  out  8  byte to UART transmit path.
REQ-010 TX_VALID  out  1  TX_DATA valid.
REQ-011 TX_READY  in  1  UART accepts byte when TX_VALID and TX_READY are both high in a cycle.
REQ-012 BUSY  out  1  high whenever state is not IDLE.
REQ-013 PKT_COUNT  out  8  count of completed packets, wraps 255->0.

Function
REQ-014 Packet = 4 bytes in order: SYNC_BYTE, STEER, {6'b0,BTN}, CSUM, where CSUM = (SYNC_BYTE+STEER+BTN byte) mod 256.
REQ-015 Tick counter counts 0..TICK_DIV-1, then wraps to 0; wrap cycle asserts internal tick for one cycle; counter free-runs regardless of state.
REQ-016 Pending flag sets on tick or on any change of (debounced) button vector versus its previous-cycle value; clears on the IDLE->LATCH transition; multiple events while pending coalesce into one packet.
REQ-017 States: IDLE, LATCH, SYNC, STEER, BTN, CSUM.
REQ-018 IDLE->LATCH when pending is set; LATCH->SYNC unconditionally next cycle; each byte state advances to the next only on a TX handshake; CSUM->IDLE on handshake.
REQ-019 LATCH snapshots steering register and button vector; packet bytes use the snapshot only; input changes during a packet do not alter it.
REQ-020 An event occurring during LATCH..CSUM sets pending; the next packet starts with IDLE->LATCH the cycle after CSUM is accepted.
REQ-021 TX_VALID high exactly in SYNC, STEER, BTN, CSUM; TX_DATA holds stable while TX_VALID is high and TX_READY is low; TX_DATA is 8'h00 when TX_VALID is low.
REQ-022 Minimum packet latency: pending set in cycle N -> LATCH in N+1 -> SYNC byte valid in N+2; with TX_READY held high, a packet occupies 4 consecutive cycles.
REQ-023 PKT_COUNT increments in the cycle after the CSUM handshake.
REQ-024 Steering register loads STEER_IN on any cycle with STEER_VALID high, including during a packet; the loaded value takes effect from the next LATCH.

Reset
REQ-025 While FAB_RST is high at a clock edge: state=IDLE, tick counter=0, pending=0, steering register=8'h80, button history=2'b00, debounce counters=0, PKT_COUNT=0, TX_VALID=0, TX_DATA=8'h00, BUSY=0.
REQ-026 Reset asserted mid-packet aborts the packet: TX_VALID is low from the cycle after the reset edge, and there is no partial resume.
REQ-027 After reset deasserts, the first packet is produced by the first tick or button change.

Configuration
REQ-028 Macro DEBOUNCE_EN: when defined, each BTN_IN bit updates its debounced value only after DEB_CYCLES consecutive identical samples differing from it, and change detection uses the debounced vector.
REQ-029 When DEBOUNCE_EN is undefined, change detection uses raw BTN_IN and DEB_CYCLES is ignored.

Verification
REQ-030 TICK_DIV=8, TX_READY=1, STEER_IN=8'h40 valid, BTN=0 -> bytes A5,40,00,E5 in 4 consecutive cycles, repeating every 8 cycles; PKT_COUNT increments by 1 per packet.
REQ-031 TX_READY toggling 1-of-3 cycles -> each byte is held stable until its handshake, with no byte lost or duplicated, and the CSUM is correct.
REQ-032 BTN 00->01 while a tick packet is in STEER state -> current packet carries BTN 00, then a second packet with BTN 01 starts immediately after.
REQ-033 FAB_RST pulsed during the BTN byte -> TX_VALID=0 next cycle, PKT_COUNT=0, STEER register=80, and no output until the next tick.
REQ-034 DEBOUNCE_EN defined, DEB_CYCLES=4, 2-cycle glitch on BTN_IN[0] -> no packet is triggered; a 5-cycle stable change triggers exactly one packet.
REQ-035 255 packets, then one more -> PKT_COUNT wraps 255->0.
